parking_gate_controller: RTL

//  Parametrised successor to the two-pool (university/general) parking manager.
//  - Arbitrates one entry gate with a req/ack handshake and a timed gate-open phase.
//  - Tracks occupancy per pool against an hour-dependent university reservation.
//  - Reports saturating vacated-space counts and flags an over-capacity condition.

---
 rtl/parking_gate_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/parking_gate_controller.sv
// Two-pool parking gate: req/ack admission, timed gate-open, hour-based uni reservation; status 1-cycle latency.
// Requests are held off (entry_busy) while the gate is open; optional PARKING_STATS_EN adds grant/deny counters.
module parking_gate_controller #(
    parameter int CAPACITY      = 700,
    parameter int UNI_RES_DAY   = 500,
    parameter int UNI_RES_NIGHT = 200,
    parameter int RAMP_START    = 13,
    parameter int RAMP_END      = 16,
    parameter int RAMP_STEP     = 50,
    parameter int GATE_CYCLES   = 4,
    parameter int CNT_W         = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       current_hour,
    input  logic             entry_req,
    input  logic             entry_is_uni,
    input  logic             car_exited,
    input  logic             is_uni_car_exited,
    output logic             entry_ack,
    output logic             entry_grant,
    output logic             entry_busy,
    output logic             gate_open,
    output logic             exit_err,
    output logic [CNT_W-1:0] uni_parked_car,
    output logic [CNT_W-1:0] parked_car,
    output logic [CNT_W-1:0] uni_vacated_space,
    output logic [CNT_W-1:0] vacated_space,
    output logic             uni_is_vacated_space,
    output logic             is_vacated_space,
    output logic             over_cap
`ifdef PARKING_STATS_EN
    ,
    output logic [15:0]      granted_count,
    output logic [15:0]      denied_count
`endif
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DENY_ACK, OPEN} state_t;

    state_t           state, state_nxt;
    logic [GW-1:0]    gate_cnt, gate_cnt_nxt;
    logic [7:0]       hour_eff;
    logic [CNT_W-1:0] res, gen_share;
    logic [CNT_W-1:0] uni_nxt, gen_nxt;
    logic             sample, admit, uni_inc, gen_inc, uni_dec, gen_dec, exit_bad;

    function automatic logic [CNT_W-1:0] res_of(input logic [7:0] h);
        int hi;
        hi = int'(h);
        if (hi < RAMP_START)
            return CNT_W'(UNI_RES_DAY);
        else if (hi < RAMP_END)
            return CNT_W'(UNI_RES_DAY - RAMP_STEP * (hi - RAMP_START + 1));
        else
            return CNT_W'(UNI_RES_NIGHT);
    endfunction

    assign hour_eff  = (current_hour > 8'd23) ? 8'd0 : current_hour;
    assign res       = res_of(hour_eff);
    assign gen_share = CNT_W'(CAPACITY) - res;

    // Admission is judged on the counts present before any same-cycle exit.
    assign admit = entry_is_uni ? (uni_parked_car < res) : (parked_car < gen_share);

    always_comb begin
        state_nxt    = state;
        gate_cnt_nxt = gate_cnt;
        sample       = 1'b0;
        case (state)
            IDLE: begin
                if (entry_req) begin
                    sample       = 1'b1;
                    gate_cnt_nxt = '0;
                    state_nxt    = admit ? OPEN : DENY_ACK;
                end
            end
            DENY_ACK: state_nxt = IDLE;
            OPEN: begin
                if (gate_cnt == GW'(GATE_CYCLES - 1))
                    state_nxt = IDLE;
                else
                    gate_cnt_nxt = gate_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gate_open  = (state == OPEN);
    assign entry_busy = (state == OPEN);

    assign uni_inc  = sample & admit & entry_is_uni;
    assign gen_inc  = sample & admit & ~entry_is_uni;
    assign uni_dec  = car_exited & is_uni_car_exited & (uni_parked_car != '0);
    assign gen_dec  = car_exited & ~is_uni_car_exited & (parked_car != '0);
    assign exit_bad = car_exited & (is_uni_car_exited ? (uni_parked_car == '0) : (parked_car == '0));
    assign uni_nxt  = uni_parked_car + {{(CNT_W-1){1'b0}}, uni_inc} - {{(CNT_W-1){1'b0}}, uni_dec};
    assign gen_nxt  = parked_car + {{(CNT_W-1){1'b0}}, gen_inc} - {{(CNT_W-1){1'b0}}, gen_dec};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            gate_cnt             <= '0;
            entry_ack            <= 1'b0;
            entry_grant          <= 1'b0;
            exit_err             <= 1'b0;
            uni_parked_car       <= '0;
            parked_car           <= '0;
            uni_vacated_space    <= '0;
            vacated_space        <= '0;
            uni_is_vacated_space <= 1'b0;
            is_vacated_space     <= 1'b0;
            over_cap             <= 1'b0;
        end else begin
            state                <= state_nxt;
            gate_cnt             <= gate_cnt_nxt;
            entry_ack            <= sample;
            entry_grant          <= sample & admit;
            exit_err             <= exit_bad;
            uni_parked_car       <= uni_nxt;
            parked_car           <= gen_nxt;
            // A share shrinking below occupancy saturates at zero; cars are never evicted.
            uni_vacated_space    <= (res > uni_nxt) ? (res - uni_nxt) : '0;
            vacated_space        <= (gen_share > gen_nxt) ? (gen_share - gen_nxt) : '0;
            uni_is_vacated_space <= (res > uni_nxt);
            is_vacated_space     <= (gen_share > gen_nxt);
            over_cap             <= (uni_nxt > res) || (gen_nxt > gen_share);
        end
    end

`ifdef PARKING_STATS_EN
    logic [7:0] hour_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_prev     <= 8'd0;
            granted_count <= 16'd0;
            denied_count  <= 16'd0;
        end else begin
            hour_prev <= current_hour;
            if (hour_prev == 8'd23 && current_hour == 8'd0) begin
                granted_count <= 16'd0;
                denied_count  <= 16'd0;
            end else if (entry_ack) begin
                if (entry_grant && granted_count != 16'hFFFF)
                    granted_count <= granted_count + 16'd1;
                else if (!entry_grant && denied_count != 16'hFFFF)
                    denied_count <= denied_count + 16'd1;
            end
        end
    end
`endif

endmodule
